// File: rtl/scan_pkg.sv
// scan_pkg
// Shared definitions for the column scan controller: the FSM state
// encoding, the column count and select-code width, and a helper that
// turns a column index into its one-hot strobe pattern.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_e;

    localparam int NUM_COLS = 7;
    localparam int SEL_W    = 3;
    localparam int LAST_COL = 6;

    // One-hot column strobe for a given index. Indices past the last
    // column never occur, but they decode to all-dark for safety.
    function automatic logic [NUM_COLS-1:0] col_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_COLS-1:0] result;
        result = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (idx == SEL_W'(i)) begin
                result[i] = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler
// Free-running column-period counter for the scan controller.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   clr    in   synchronous clear to zero (wins over inc)
//   inc    in   increment enable
//   count  out  current count value (DIV_W bits)
//   tc     out  terminal count flag, high while count == DIV_MAX
module scan_prescaler #(
    parameter int DIV_W   = 16,
    parameter int DIV_MAX = 49999
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [DIV_W-1:0] count,
    output logic             tc
);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == DIV_W'(DIV_MAX));

endmodule

// File: rtl/column_scan_controller.sv
// column_scan_controller
// Steps a 3-bit select code through columns 0..6 for the downstream
// 7-way display multiplexer, with a one-hot column strobe lit only while
// that column's data is selected, and a FRAME pulse once per full scan.
// Build option: define SCAN_BLANK_EN to insert BLANK_CYCLES dark cycles
// at the start of every column so the multiplexer output can settle.
// Ports:
//   CLK          in   system clock
//   RST_N        in   asynchronous active-low reset
//   EN           in   scan enable
//   SEL0..SEL2   out  select code, SEL0 = index bit 2, SEL2 = index bit 0
//   COL0..COL6   out  one-hot active-high column strobes
//   FRAME        out  one-cycle pulse after the index wraps 6 -> 0
module column_scan_controller
    import scan_pkg::*;
#(
    parameter int DIV_MAX      = 49999,
    parameter int DIV_W        = 16,
    parameter int BLANK_CYCLES = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic EN,
    output logic SEL0,
    output logic SEL1,
    output logic SEL2,
    output logic COL0,
    output logic COL1,
    output logic COL2,
    output logic COL3,
    output logic COL4,
    output logic COL5,
    output logic COL6,
    output logic FRAME
);

    // Every column period begins here; without blanking a column is lit
    // from its very first cycle.
`ifdef SCAN_BLANK_EN
    localparam scan_state_e COL_START = BLANK;
`else
    localparam scan_state_e COL_START = SHOW;
`endif

    scan_state_e         state_q, state_d;
    logic [SEL_W-1:0]    index_q, index_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [NUM_COLS-1:0] col_q, col_d;
    logic                frame_q, frame_d;

    logic             pre_clr;
    logic             pre_inc;
    logic [DIV_W-1:0] pre_count;
    logic             pre_tc;
    logic             wrap;

    scan_prescaler #(
        .DIV_W   (DIV_W),
        .DIV_MAX (DIV_MAX)
    ) u_prescaler (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (pre_clr),
        .inc   (pre_inc),
        .count (pre_count),
        .tc    (pre_tc)
    );

    // Next-state logic. Dropping EN wins over the terminal count and the
    // index wrap, so an abandoned column never produces a FRAME pulse.
    // The prescaler keeps running from BLANK into SHOW so the whole
    // column period is measured by one count.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        pre_clr = 1'b0;
        pre_inc = 1'b0;
        wrap    = 1'b0;
        case (state_q)
            IDLE: begin
                pre_clr = 1'b1;
                index_d = '0;
                if (EN) begin
                    state_d = COL_START;
                end
            end
            BLANK: begin
                if (!EN) begin
                    state_d = IDLE;
                    pre_clr = 1'b1;
                    index_d = '0;
                end else begin
                    pre_inc = 1'b1;
                    if (pre_count == DIV_W'(BLANK_CYCLES - 1)) begin
                        state_d = SHOW;
                    end
                end
            end
            SHOW: begin
                if (!EN) begin
                    state_d = IDLE;
                    pre_clr = 1'b1;
                    index_d = '0;
                end else if (pre_tc) begin
                    pre_clr = 1'b1;
                    state_d = COL_START;
                    if (index_q == SEL_W'(LAST_COL)) begin
                        index_d = '0;
                        wrap    = 1'b1;
                    end else begin
                        index_d = index_q + SEL_W'(1);
                    end
                end else begin
                    pre_inc = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                pre_clr = 1'b1;
                index_d = '0;
            end
        endcase
    end

    // Output flops present the current state one cycle later, so SEL and
    // COL always move together on the same edge. A transition into IDLE
    // clears them on the very edge that samples EN low.
    always_comb begin
        sel_d   = '0;
        col_d   = '0;
        frame_d = wrap;
        if (state_d != IDLE) begin
            sel_d = index_q;
            if (state_q == SHOW) begin
                col_d = col_onehot(index_q);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            index_q <= '0;
            sel_q   <= '0;
            col_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            sel_q   <= sel_d;
            col_q   <= col_d;
            frame_q <= frame_d;
        end
    end

    assign SEL0  = sel_q[2];
    assign SEL1  = sel_q[1];
    assign SEL2  = sel_q[0];
    assign COL0  = col_q[0];
    assign COL1  = col_q[1];
    assign COL2  = col_q[2];
    assign COL3  = col_q[3];
    assign COL4  = col_q[4];
    assign COL5  = col_q[5];
    assign COL6  = col_q[6];
    assign FRAME = frame_q;

endmodule

// File: tb/tb_column_scan_controller.sv
// tb_column_scan_controller
// Self-checking bench for column_scan_controller with DIV_MAX=7 and
// BLANK_CYCLES=2. A position model predicts the outputs for every clock
// edge; predictions are queued when stimulus is driven and popped once
// the DUT has produced its outputs for that edge.
module tb_column_scan_controller;

    localparam int DIV_MAX   = 7;
    localparam int BLANK     = 2;
    localparam int PERIOD    = DIV_MAX + 1;
    localparam int FRAME_LEN = 7 * PERIOD;
`ifdef SCAN_BLANK_EN
    localparam int DARK = BLANK;
`else
    localparam int DARK = 0;
`endif

    logic CLK;
    logic RST_N;
    logic EN;
    logic SEL0, SEL1, SEL2;
    logic COL0, COL1, COL2, COL3, COL4, COL5, COL6;
    logic FRAME;

    int total;
    int bad;
    int model_pos;
    logic [10:0] exp_q[$];

    column_scan_controller #(
        .DIV_MAX      (DIV_MAX),
        .DIV_W        (16),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .EN    (EN),
        .SEL0  (SEL0),
        .SEL1  (SEL1),
        .SEL2  (SEL2),
        .COL0  (COL0),
        .COL1  (COL1),
        .COL2  (COL2),
        .COL3  (COL3),
        .COL4  (COL4),
        .COL5  (COL5),
        .COL6  (COL6),
        .FRAME (FRAME)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Packed view of all outputs: {SEL0,SEL1,SEL2, COL6..COL0, FRAME}
    function automatic logic [10:0] outs();
        return {SEL0, SEL1, SEL2, COL6, COL5, COL4, COL3, COL2, COL1, COL0, FRAME};
    endfunction

    // Drives EN/RST_N for one edge, pushes the model's prediction for the
    // outputs right after that edge, then waits until just past the edge.
    // model_pos is the position within the scan held by the DUT registers
    // (-1 = idle); outputs after an edge describe the previous position.
    task automatic drive_cycle(input logic en_val, input logic rstn_val);
        logic [10:0] exp_v;
        logic [2:0]  idx;
        logic [6:0]  col;
        logic        fr;
        int          m;
        @(negedge CLK);
        EN    = en_val;
        RST_N = rstn_val;
        exp_v = '0;
        if (!rstn_val || !en_val) begin
            model_pos = -1;
        end else if (model_pos < 0) begin
            model_pos = 0;
        end else begin
            m         = model_pos;
            idx       = 3'((m / PERIOD) % 7);
            col       = ((m % PERIOD) >= DARK) ? (7'b1 << idx) : 7'b0;
            model_pos = m + 1;
            fr        = ((model_pos % FRAME_LEN) == 0);
            exp_v     = {idx, col, fr};
        end
        exp_q.push_back(exp_v);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] exp_v;
        logic [10:0] got;
        RST_N = 1'b0;
        EN    = 1'b1;
        #1;
        total++;
        if (outs() !== 11'b0) begin
            bad++;
            $display("[TB] FAIL reset_async got=%b want=%b", outs(), 11'b0);
        end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 1'b0);
            exp_v = exp_q.pop_front();
            got   = outs();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("[TB] FAIL reset_hold cyc=%0d got=%b want=%b", i, got, exp_v);
            end
        end
        // Release and let COL0 come up after the first enabled edge.
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, 1'b1);
            exp_v = exp_q.pop_front();
            got   = outs();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("[TB] FAIL reset_release cyc=%0d got=%b want=%b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_full_frame();
        logic [10:0] exp_v;
        logic [10:0] got;
        int frames;
        int sevens;
        frames = 0;
        sevens = 0;
        drive_cycle(1'b0, 1'b1);
        exp_v = exp_q.pop_front();
        got   = outs();
        total++;
        if (got !== exp_v) begin
            bad++;
            $display("[TB] FAIL frame_idle got=%b want=%b", got, exp_v);
        end
        for (int i = 0; i < 120; i++) begin
            drive_cycle(1'b1, 1'b1);
            exp_v = exp_q.pop_front();
            got   = outs();
            if (FRAME === 1'b1) frames++;
            if ({SEL0, SEL1, SEL2} === 3'b111) sevens++;
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("[TB] FAIL full_frame cyc=%0d got=%b want=%b", i, got, exp_v);
            end
        end
        total++;
        if (frames !== 2) begin
            bad++;
            $display("[TB] FAIL frame_count got=%0d want=%0d", frames, 2);
        end
        total++;
        if (sevens !== 0) begin
            bad++;
            $display("[TB] FAIL sel_seven got=%0d want=%0d", sevens, 0);
        end
    endtask

    task automatic test_mid_disable();
        logic [10:0] exp_v;
        logic [10:0] got;
        int guard;
        drive_cycle(1'b0, 1'b1);
        void'(exp_q.pop_front());
        guard = 0;
        // Run to index 3, prescaler 4, then drop EN.
        while (model_pos != 3 * PERIOD + 4 && guard < 200) begin
            drive_cycle(1'b1, 1'b1);
            exp_v = exp_q.pop_front();
            got   = outs();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("[TB] FAIL mid_run cyc=%0d got=%b want=%b", guard, got, exp_v);
            end
            guard++;
        end
        drive_cycle(1'b0, 1'b1);
        exp_v = exp_q.pop_front();
        got   = outs();
        total++;
        if (got !== exp_v) begin
            bad++;
            $display("[TB] FAIL mid_disable got=%b want=%b", got, exp_v);
        end
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b1, 1'b1);
            exp_v = exp_q.pop_front();
            got   = outs();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("[TB] FAIL mid_restart cyc=%0d got=%b want=%b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [10:0] exp_v;
        logic [10:0] got;
        int guard;
        guard = 0;
        // Continue until the outputs show column 5 lit.
        while (model_pos != 5 * PERIOD + 4 && guard < 200) begin
            drive_cycle(1'b1, 1'b1);
            exp_v = exp_q.pop_front();
            got   = outs();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("[TB] FAIL async_run cyc=%0d got=%b want=%b", guard, got, exp_v);
            end
            guard++;
        end
        total++;
        if (COL5 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL async_col5_lit got=%b want=%b", COL5, 1'b1);
        end
        #2;
        RST_N = 1'b0;
        #1;
        total++;
        if (outs() !== 11'b0) begin
            bad++;
            $display("[TB] FAIL async_reset got=%b want=%b", outs(), 11'b0);
        end
        drive_cycle(1'b1, 1'b0);
        exp_v = exp_q.pop_front();
        got   = outs();
        total++;
        if (got !== exp_v) begin
            bad++;
            $display("[TB] FAIL async_hold got=%b want=%b", got, exp_v);
        end
    endtask

    task automatic test_wrap_collision();
        logic [10:0] exp_v;
        logic [10:0] got;
        int guard;
        guard = 0;
        // Stop at the last cycle of column 6 and drop EN on the wrap edge.
        while (model_pos != FRAME_LEN - 1 && guard < 200) begin
            drive_cycle(1'b1, 1'b1);
            exp_v = exp_q.pop_front();
            got   = outs();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("[TB] FAIL wrap_run cyc=%0d got=%b want=%b", guard, got, exp_v);
            end
            guard++;
        end
        drive_cycle(1'b0, 1'b1);
        exp_v = exp_q.pop_front();
        got   = outs();
        total++;
        if (got !== exp_v || FRAME !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wrap_collision got=%b want=%b", got, exp_v);
        end
        for (int i = 0; i < 6; i++) begin
            drive_cycle(i > 0, 1'b1);
            exp_v = exp_q.pop_front();
            got   = outs();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("[TB] FAIL wrap_restart cyc=%0d got=%b want=%b", i, got, exp_v);
            end
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        model_pos = -1;
        RST_N     = 1'b0;
        EN        = 1'b0;
        test_reset();
        test_full_frame();
        test_mid_disable();
        test_async_reset();
        test_wrap_collision();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
